// File: rtl/wb_slave_mem_if.sv
// ---------------------------------------------------------------------------
// wb_slave_mem_if
// Wishbone B3 bus bundle between an initiator and wb_slave_mem.
// Signal names are written from the responder's side: *_i are driven by
// the master, *_o are driven by the slave.
//   cyc_i, stb_i, we_i   : cycle, strobe, write enable
//   adr_i[31:0]          : byte address (bits [1:0] ignored)
//   sel_i[3:0]           : byte enables, sel_i[3] -> dat[31:24]
//   cti_i[2:0], bte_i[1:0]: cycle type / burst type
//   dat_i[31:0]          : write data
//   dat_o[31:0]          : read data
//   ack_o, err_o         : normal / error termination
// Handshake: a beat completes on the rising clock edge at which the master
// holds cyc_i & stb_i and the slave holds ack_o or err_o; the master keeps
// every request field stable until that edge.
// ---------------------------------------------------------------------------
interface wb_slave_mem_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [31:0] adr_i;
   logic [3:0]  sel_i;
   logic [2:0]  cti_i;
   logic [1:0]  bte_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, cti_i, bte_i, dat_i,
      output dat_o, ack_o, err_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, cti_i, bte_i, dat_i,
      input  dat_o, ack_o, err_o
   );
endinterface

// File: rtl/wb_slave_mem.sv
// ---------------------------------------------------------------------------
// wb_slave_mem
// Wishbone B3 responder memory model: single-port 32-bit word RAM with
// programmable wait states before the first ack, byte selects and
// registered-feedback bursts (cti 010 / 111, bte linear / wrap4/8/16).
//
// Optional build macro: WB_SLAVE_ERR_EN
//   defined   : addresses outside BASE_ADR .. BASE_ADR+4*2^AW-1 terminate
//               with err_o instead of ack_o, never write, and end a burst.
//   undefined : err_o is constant 0 and out-of-window addresses alias onto
//               the RAM through the truncated word index.
//
// Ports:
//   clk         : bus clock, rising edge
//   reset       : asynchronous, active-high
//   bus         : wb_slave_mem_if.slave (cyc/stb/we/adr/sel/cti/bte/dat in,
//                 dat/ack/err out)
//   o_dbg_state : current FSM state (0 IDLE, 1 WAIT, 2 ACK, 3 BURST)
// ---------------------------------------------------------------------------
module wb_slave_mem #(
   parameter logic [31:0] BASE_ADR    = 32'h0000_1000,
   parameter int          AW          = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          reset,
   wb_slave_mem_if.slave bus,
   output logic [1:0]    o_dbg_state
);

`ifdef WB_SLAVE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int         DEPTH    = 1 << AW;
   localparam logic [2:0] CTI_INCR = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ACK   = 2'd2,
      S_BURST = 2'd3
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [29:0] r_off;     // full word offset from BASE_ADR; low AW bits index the RAM
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_dat;     // prefetched read word for the current/next ack cycle
   logic [31:0] r_mem [DEPTH];

   logic [31:0]   w_diff;
   logic [29:0]   w_req_off;
   logic [1:0]    w_unused_adr;
   logic [29:0]   w_adv_off;
   logic [AW-1:0] w_idx;
   logic          w_req;
   logic          w_beat;
   logic          w_cur_oor;
   logic          w_req_oor;
   logic          w_wr_en;

   // Word offsets whose bits above AW are non-zero fall outside the window;
   // only reported when the error feature is built in.
   function automatic logic oor(input logic [29:0] off);
      return ERR_EN && (off[29:AW] != '0);
   endfunction

   // Burst address advance: linear bumps the whole offset (RAM index wraps
   // modulo 2^AW by truncation), wrap modes only count within 4/8/16 words.
   function automatic logic [29:0] advance(input logic [29:0] off, input logic [1:0] bte);
      logic [29:0] nxt;
      nxt = off + 30'd1;
      case (bte)
         2'b01:   nxt = {off[29:2], nxt[1:0]};
         2'b10:   nxt = {off[29:3], nxt[2:0]};
         2'b11:   nxt = {off[29:4], nxt[3:0]};
         default: nxt = off + 30'd1;
      endcase
      return nxt;
   endfunction

   assign w_diff       = bus.adr_i - BASE_ADR;
   assign w_req_off    = w_diff[31:2];
   assign w_unused_adr = w_diff[1:0];
   assign w_adv_off    = advance(r_off, bus.bte_i);
   assign w_idx        = r_off[AW-1:0];
   assign w_req        = bus.cyc_i & bus.stb_i;
   assign w_cur_oor    = oor(r_off);
   assign w_req_oor    = oor(w_req_off);

   // In BURST the slave runs with zero wait states, so the termination of a
   // beat follows the strobe directly; everywhere else it is the register.
   assign w_beat    = (r_state == S_BURST) & w_req;
   assign bus.ack_o = r_ack | (w_beat & ~w_cur_oor);
   assign bus.err_o = r_err | (w_beat &  w_cur_oor);
   assign bus.dat_o = bus.ack_o ? r_dat : 32'd0;

   assign w_wr_en = w_req & bus.we_i &
                    (((r_state == S_ACK) & r_ack) | ((r_state == S_BURST) & ~w_cur_oor));

   assign o_dbg_state = r_state;

   // RAM is never reset; a write is blocked while reset is high so an
   // interrupted cycle cannot leave a partial update behind.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.sel_i[b]) r_mem[w_idx][8*b +: 8] <= bus.dat_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_off   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
      end else if (!bus.cyc_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.stb_i) begin
                  r_off <= w_req_off;
                  if (WAIT_STATES == 0) begin
                     r_state <= S_ACK;
                     r_cnt   <= '0;
                     r_ack   <= ~w_req_oor;
                     r_err   <= w_req_oor;
                     r_dat   <= r_mem[w_req_off[AW-1:0]];
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= 4'(WAIT_STATES);
                  end
               end
            end
            S_WAIT: begin
               // The counter reaches zero on the edge that enters ACK, so WAIT
               // lasts exactly WAIT_STATES cycles.
               if (r_cnt <= 4'd1) begin
                  r_state <= S_ACK;
                  r_cnt   <= '0;
                  r_ack   <= ~w_cur_oor;
                  r_err   <= w_cur_oor;
                  r_dat   <= r_mem[w_idx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ACK: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               r_dat <= '0;
               if (r_ack && bus.stb_i && (bus.cti_i == CTI_INCR)) begin
                  r_state <= S_BURST;
                  r_off   <= w_adv_off;
                  r_dat   <= r_mem[w_adv_off[AW-1:0]];
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_BURST: begin
               if (bus.stb_i) begin
                  if (w_cur_oor || (bus.cti_i != CTI_INCR)) begin
                     r_state <= S_IDLE;
                     r_dat   <= '0;
                  end else begin
                     r_off <= w_adv_off;
                     r_dat <= r_mem[w_adv_off[AW-1:0]];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
